// File: rtl/wrr_burst_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin burst arbiter.
package arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  // Index width that stays at least 1 bit for degenerate counts.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wrr_burst_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at/after ptr, circularly.
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [IDX_W-1:0]   win_idx
);

  logic [2*NUM_REQ-1:0] dbl_req, dbl_win;
  logic [NUM_REQ-1:0]   rot_req, rot_win;

  // Rotate so ptr lands at bit 0, fixed-priority pick, rotate back.
  assign dbl_req = {req, req} >> ptr;
  assign rot_req = dbl_req[NUM_REQ-1:0];

  always_comb begin
    rot_win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (rot_req[i]) rot_win = NUM_REQ'(1) << i;
  end

  assign dbl_win = {rot_win, rot_win} << ptr;
  assign win     = dbl_win[2*NUM_REQ-1:NUM_REQ];

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win[i]) win_idx = IDX_W'(i);
  end

endmodule

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter holding a registered grant for whole bursts.
module wrr_burst_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int WEIGHT_W = 2,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           last,
  input  logic [NUM_REQ*WEIGHT_W-1:0]  weight,
  input  logic                         rsrc_ready,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         gnt_vld,
  output logic [IDX_W-1:0]             gnt_idx,
  output logic                         abort
);

  arb_state_e          state;
  logic [IDX_W-1:0]    ptr;
  logic [WEIGHT_W-1:0] credit;
  logic [NUM_REQ-1:0]  win;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    ptr_nxt;
  logic                own_req, fire, burst_end;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx)
  );

  assign own_req   = req[gnt_idx];
  assign fire      = (state == ARB_BUSY) && own_req && rsrc_ready;
  assign burst_end = fire && last[gnt_idx];
  assign ptr_nxt   = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
  assign gnt_vld   = |gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB_IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      ptr     <= '0;
      credit  <= '0;
      abort   <= 1'b0;
    end else begin
      abort <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (|req) begin
            state   <= ARB_BUSY;
            gnt     <= win;
            gnt_idx <= win_idx;
            credit  <= weight[int'(win_idx)*WEIGHT_W +: WEIGHT_W];
          end
        end
        ARB_BUSY: begin
          // burst_end implies own_req, so credit alone decides extension.
          if (burst_end && credit != '0) begin
            credit <= credit - WEIGHT_W'(1);
          end else if (burst_end || !own_req) begin
            abort   <= !burst_end;
            state   <= ARB_IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            ptr     <= ptr_nxt;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Directed bench for wrr_burst_arbiter (NUM_REQ=4, WEIGHT_W=2).
module tb_wrr_burst_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, last, gnt;
  logic [7:0] weight;
  logic       rsrc_ready, gnt_vld, abort;
  logic [1:0] gnt_idx;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  wrr_burst_arbiter #(.NUM_REQ(4), .WEIGHT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .last       (last),
    .weight     (weight),
    .rsrc_ready (rsrc_ready),
    .gnt        (gnt),
    .gnt_vld    (gnt_vld),
    .gnt_idx    (gnt_idx),
    .abort      (abort)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; last = '0; weight = '0; rsrc_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] order [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // 1: reset state, basic grant, 3-beat burst, wrap search from ptr=2
    do_reset();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_vld", gnt_vld, 1'b0);
    chk("rst_idx", gnt_idx, 2'd0);
    chk("rst_abort", abort, 1'b0);
    req = 4'b1010;
    step();
    chk("t1_gnt", gnt, 4'b0010);
    chk("t1_idx", gnt_idx, 2'd1);
    chk("t1_vld", gnt_vld, 1'b1);
    step();                         // beat 1
    step();                         // beat 2
    chk("t1_hold", gnt, 4'b0010);
    last = 4'b0010;
    step();                         // beat 3, last
    chk("t1_bubble", gnt, 4'b0000);
    last = 4'b0000;
    step();
    chk("t1_wrap_gnt", gnt, 4'b1000);
    chk("t1_wrap_idx", gnt_idx, 2'd3);

    // 2: weight 2 -> three back-to-back bursts, bubble, regrant
    do_reset();
    weight = 8'b00_00_00_10;
    req = 4'b0001; last = 4'b0001;
    step();
    chk("t2_gnt", gnt, 4'b0001);
    weight = 8'b00_00_00_00;        // must not affect the loaded credit
    step();
    chk("t2_b1_keep", gnt, 4'b0001);
    step();
    chk("t2_b2_keep", gnt, 4'b0001);
    step();
    chk("t2_b3_rel", gnt, 4'b0000);
    step();
    chk("t2_regrant", gnt, 4'b0001);

    // 3: all requesting, weight 0 -> 0,1,2,3,0 with a bubble between each
    do_reset();
    req = 4'b1111; last = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("t3_gnt%0d", k), gnt, order[k]);
      step();
      chk($sformatf("t3_bub%0d", k), gnt, 4'b0000);
    end

    // 4: owner 2 drops req mid-burst -> abort, then 3 wins
    do_reset();
    req = 4'b0100;
    step();
    chk("t4_gnt", gnt, 4'b0100);
    step();
    req = 4'b1000;
    step();
    chk("t4_abort", abort, 1'b1);
    chk("t4_gnt0", gnt, 4'b0000);
    step();
    chk("t4_abort_clr", abort, 1'b0);
    chk("t4_next", gnt, 4'b1000);
    chk("t4_next_idx", gnt_idx, 2'd3);

    // 5: stall 10 cycles on last beat; credit must survive the stall
    do_reset();
    weight = 8'b00_00_00_01;
    req = 4'b0001;
    step();
    chk("t5_gnt", gnt, 4'b0001);
    rsrc_ready = 1'b0; last = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("t5_stall%0d", k), gnt, 4'b0001);
    end
    rsrc_ready = 1'b1;
    step();
    chk("t5_ext", gnt, 4'b0001);
    step();
    chk("t5_rel", gnt, 4'b0000);
    chk("t5_no_abort", abort, 1'b0);

    // 6: reset while busy with credit 3
    do_reset();
    weight = 8'b00_00_00_11;
    req = 4'b0001;
    step();
    chk("t6_gnt", gnt, 4'b0001);
    rst = 1'b1;
    step();
    chk("t6_rst_gnt", gnt, 4'b0000);
    chk("t6_rst_idx", gnt_idx, 2'd0);
    chk("t6_rst_abort", abort, 1'b0);
    rst = 1'b0; req = 4'b1000;
    step();
    chk("t6_gnt3", gnt, 4'b1000);
    chk("t6_idx3", gnt_idx, 2'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
